// File: rtl/combo_pkg.sv
// Shared types and constants for the combination-lock dialer and receiver.
package combo_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SEND        = 3'd1,
        GAP         = 3'd2,
        WAIT_RESULT = 3'd3,
        DONE        = 3'd4
    } dialer_state_t;

    // A digit is acceptable when it is a decimal digit.
    function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
        return d <= DIGIT_MAX;
    endfunction

endpackage

// File: rtl/combo_code_store.sv
// Code register file: append, clear and read-by-index for the dialer.
module combo_code_store
    import combo_pkg::*;
#(
    parameter int unsigned NDIGITS = 6,
    parameter int unsigned IDX_W   = $clog2(NDIGITS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [DIGIT_W-1:0] load_digit,
    input  logic               clear,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [DIGIT_W-1:0] rd_digit_c,
    output logic [3:0]         load_count,
    output logic               code_full,
    output logic               load_err
);

    logic [DIGIT_W-1:0] mem [NDIGITS];

    assign rd_digit_c = mem[rd_idx];

    // Clear has priority over a simultaneous load and never flags an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NDIGITS; i++) begin
                mem[i] <= '0;
            end
            load_count <= 4'd0;
            code_full  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            load_err <= 1'b0;
            if (clear) begin
                load_count <= 4'd0;
                code_full  <= 1'b0;
            end else if (load_en) begin
                if (!digit_ok(load_digit) || code_full) begin
                    load_err <= 1'b1;
                end else begin
                    mem[IDX_W'(load_count)] <= load_digit;
                    load_count <= load_count + 4'd1;
                    code_full  <= (load_count == 4'(NDIGITS - 1));
                end
            end
        end
    end

endmodule

// File: rtl/combo_dialer.sv
// Sends a stored decimal code to a lock over valid/ready and reports the verdict.
// Optional wait-for-verdict timeout: define COMBO_DIALER_TIMEOUT_EN.
module combo_dialer
    import combo_pkg::*;
#(
    parameter int unsigned NDIGITS        = 6,
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [DIGIT_W-1:0] load_digit,
    input  logic               clear,
    input  logic               start,
    output logic [DIGIT_W-1:0] digit_out,
    output logic               digit_valid,
    input  logic               digit_ready,
    input  logic               lock_open,
    input  logic               lock_closed,
    output logic               busy,
    output logic               code_full,
    output logic [3:0]         load_count,
    output logic               load_err,
    output logic               opened,
    output logic               failed
);

    localparam int unsigned IDX_W = $clog2(NDIGITS);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [2:0] S_IDLE = 3'(IDLE);
    localparam logic [2:0] S_SEND = 3'(SEND);
    localparam logic [2:0] S_GAP  = 3'(GAP);
    localparam logic [2:0] S_WAIT = 3'(WAIT_RESULT);
    localparam logic [2:0] S_DONE = 3'(DONE);

    if (NDIGITS < 2 || NDIGITS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("combo_dialer: parameter out of range");
    end

    logic [2:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               valid_d, busy_d, opened_d, failed_d;
    logic [DIGIT_W-1:0] digit_d, rd_digit_c;
    logic               idle_c, hs_c;

`ifdef COMBO_DIALER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    assign idle_c = (state_q == S_IDLE);
    assign hs_c   = (state_q == S_SEND) && digit_valid && digit_ready;

    // Commands only reach the store while idle, so busy-time loads are silent.
    combo_code_store #(
        .NDIGITS (NDIGITS),
        .IDX_W   (IDX_W)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en & idle_c),
        .load_digit (load_digit),
        .clear      (clear & idle_c),
        .rd_idx     (idx_d),
        .rd_digit_c (rd_digit_c),
        .load_count (load_count),
        .code_full  (code_full),
        .load_err   (load_err)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            gap_q       <= '0;
            digit_out   <= '0;
            digit_valid <= 1'b0;
            busy        <= 1'b0;
            opened      <= 1'b0;
            failed      <= 1'b0;
`ifdef COMBO_DIALER_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            digit_out   <= digit_d;
            digit_valid <= valid_d;
            busy        <= busy_d;
            opened      <= opened_d;
            failed      <= failed_d;
`ifdef COMBO_DIALER_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    // Next state; outputs are derived from the next state so they register in step.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        opened_d = opened;
        failed_d = failed;
`ifdef COMBO_DIALER_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && code_full && !clear) begin
                    state_d  = S_SEND;
                    idx_d    = '0;
                    opened_d = 1'b0;
                    failed_d = 1'b0;
                end
            end
            S_SEND: begin
                if (hs_c) begin
                    if (idx_q == IDX_W'(NDIGITS - 1)) begin
                        state_d = S_WAIT;
`ifdef COMBO_DIALER_TIMEOUT_EN
                        tmo_d   = TMO_W'(TIMEOUT_CYCLES);
`endif
                    end else if (GAP_CYCLES == 0) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        state_d = S_GAP;
                        gap_d   = GAP_W'(GAP_CYCLES);
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(1)) begin
                    state_d = S_SEND;
                    idx_d   = idx_q + IDX_W'(1);
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            S_WAIT: begin
                // A closed verdict wins even when open arrives in the same cycle.
                if (lock_closed) begin
                    failed_d = 1'b1;
                    state_d  = S_DONE;
                end else if (lock_open) begin
                    opened_d = 1'b1;
                    state_d  = S_DONE;
                end
`ifdef COMBO_DIALER_TIMEOUT_EN
                else if (tmo_q == TMO_W'(1)) begin
                    failed_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        valid_d = (state_d == S_SEND);
        busy_d  = (state_d != S_IDLE);
        digit_d = valid_d ? rd_digit_c : digit_out;
    end

endmodule

// File: tb/tb_combo_dialer.sv
// Scoreboard bench: two dialers (no gap / 2-cycle gap) against a queue-based code model.
module tb_combo_dialer;

    localparam int ND  = 6;
    localparam int G1  = 2;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       rst, load_en, clear, start, digit_ready, lock_open, lock_closed;
    logic [3:0] load_digit;

    logic [3:0] d_out [2];
    logic [3:0] lcnt [2];
    logic       d_valid [2];
    logic       busy [2];
    logic       full [2];
    logic       lerr [2];
    logic       opened [2];
    logic       failed [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [3:0] code_m[$];
    int         cnt_m = 0;
    logic       opened_m = 1'b0;
    logic       failed_m = 1'b0;

    logic [3:0] exp_q0[$];
    logic [3:0] exp_q1[$];
    int         hs_cnt [2];
    int         entry_cyc [2];

    combo_dialer #(.NDIGITS(ND), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO)) dut0 (
        .clk(clk), .rst(rst), .load_en(load_en), .load_digit(load_digit), .clear(clear),
        .start(start), .digit_out(d_out[0]), .digit_valid(d_valid[0]), .digit_ready(digit_ready),
        .lock_open(lock_open), .lock_closed(lock_closed), .busy(busy[0]), .code_full(full[0]),
        .load_count(lcnt[0]), .load_err(lerr[0]), .opened(opened[0]), .failed(failed[0])
    );

    combo_dialer #(.NDIGITS(ND), .GAP_CYCLES(G1), .TIMEOUT_CYCLES(TMO)) dut1 (
        .clk(clk), .rst(rst), .load_en(load_en), .load_digit(load_digit), .clear(clear),
        .start(start), .digit_out(d_out[1]), .digit_valid(d_valid[1]), .digit_ready(digit_ready),
        .lock_open(lock_open), .lock_closed(lock_closed), .busy(busy[1]), .code_full(full[1]),
        .load_count(lcnt[1]), .load_err(lerr[1]), .opened(opened[1]), .failed(failed[1])
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the expected digit on every handshake, checks hold-while-stalled and gap length.
    initial begin : monitor
        int         left;
        int         gap_run [2];
        logic       gap_pend [2];
        logic       stall [2];
        logic [3:0] stall_d [2];
        logic [3:0] e;
        for (int i = 0; i < 2; i++) begin
            gap_run[i] = 0; gap_pend[i] = 1'b0; stall[i] = 1'b0; stall_d[i] = '0;
            hs_cnt[i] = 0; entry_cyc[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    hs_cnt[i] = 0; gap_pend[i] = 1'b0; stall[i] = 1'b0; gap_run[i] = 0;
                end else begin
                    if (stall[i]) begin
                        chk($sformatf("hold_valid%0d", i), int'(d_valid[i]), 1);
                        chk($sformatf("hold_digit%0d", i), int'(d_out[i]), int'(stall_d[i]));
                    end
                    stall[i] = 1'b0;
                    if (gap_pend[i]) begin
                        if (d_valid[i]) begin
                            chk($sformatf("gap_len%0d", i), gap_run[i], (i == 0) ? 0 : G1);
                            gap_pend[i] = 1'b0;
                        end else begin
                            gap_run[i]++;
                        end
                    end
                    if (d_valid[i] && digit_ready) begin
                        left = 0;
                        if (i == 0 ? exp_q0.size() == 0 : exp_q1.size() == 0) begin
                            chk($sformatf("extra_digit%0d", i), 1, 0);
                        end else begin
                            if (i == 0) begin e = exp_q0.pop_front(); left = exp_q0.size(); end
                            else        begin e = exp_q1.pop_front(); left = exp_q1.size(); end
                            chk($sformatf("digit%0d", i), int'(d_out[i]), int'(e));
                        end
                        hs_cnt[i]++;
                        if (left > 0) begin
                            gap_pend[i] = 1'b1;
                            gap_run[i]  = 0;
                        end else begin
                            entry_cyc[i] = cyc + 1;
                        end
                    end else if (d_valid[i]) begin
                        stall[i]   = 1'b1;
                        stall_d[i] = d_out[i];
                    end
                end
            end
            if (rst) begin
                exp_q0.delete();
                exp_q1.delete();
            end
        end
    end

    task automatic do_load(input logic [3:0] d, input logic with_clear);
        logic rej;
        load_en = 1'b1; load_digit = d; clear = with_clear;
        tick();
        load_en = 1'b0; clear = 1'b0;
        rej = 1'b0;
        if (with_clear) begin
            cnt_m = 0;
            code_m.delete();
        end else if (d > 4'd9 || cnt_m == ND) begin
            rej = 1'b1;
        end else begin
            code_m.push_back(d);
            cnt_m++;
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("load_err%0d", i), int'(lerr[i]), int'(rej));
            chk($sformatf("load_count%0d", i), int'(lcnt[i]), cnt_m);
            chk($sformatf("code_full%0d", i), int'(full[i]), int'(cnt_m == ND));
        end
    endtask

    task automatic do_start(input logic go);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (go) begin
            opened_m = 1'b0;
            failed_m = 1'b0;
            hs_cnt[0] = 0;
            hs_cnt[1] = 0;
            foreach (code_m[k]) begin
                exp_q0.push_back(code_m[k]);
                exp_q1.push_back(code_m[k]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("start_busy%0d", i), int'(busy[i]), int'(go));
            chk($sformatf("start_valid%0d", i), int'(d_valid[i]), int'(go));
            chk($sformatf("start_opened%0d", i), int'(opened[i]), int'(opened_m));
            chk($sformatf("start_failed%0d", i), int'(failed[i]), int'(failed_m));
            if (go) chk($sformatf("first_digit%0d", i), int'(d_out[i]), int'(code_m[0]));
        end
    endtask

    task automatic wait_sent(input logic rnd);
        int n = 0;
        while (!(hs_cnt[0] == ND && hs_cnt[1] == ND) && n < 1000) begin
            digit_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            n++;
        end
        digit_ready = 1'b0;
        chk("send_complete", int'(hs_cnt[0] == ND && hs_cnt[1] == ND), 1);
    endtask

    task automatic verdict(input logic o, input logic c);
        lock_open = o; lock_closed = c;
        tick();
        lock_open = 1'b0; lock_closed = 1'b0;
        if (c) failed_m = 1'b1;
        else if (o) opened_m = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("opened%0d", i), int'(opened[i]), int'(opened_m));
            chk($sformatf("failed%0d", i), int'(failed[i]), int'(failed_m));
            chk($sformatf("done_busy%0d", i), int'(busy[i]), 1);
        end
        tick();
        for (int i = 0; i < 2; i++) chk($sformatf("idle_busy%0d", i), int'(busy[i]), 0);
    endtask

    task automatic random_verdict();
        int v = $urandom_range(0, 2);
        verdict(v != 1, v != 0);
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; clear = 1'b0; start = 1'b0; digit_ready = 1'b0;
        lock_open = 1'b0; lock_closed = 1'b0; load_digit = '0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_busy%0d", i), int'(busy[i]), 0);
            chk($sformatf("rst_valid%0d", i), int'(d_valid[i]), 0);
            chk($sformatf("rst_digit%0d", i), int'(d_out[i]), 0);
            chk($sformatf("rst_count%0d", i), int'(lcnt[i]), 0);
            chk($sformatf("rst_full%0d", i), int'(full[i]), 0);
            chk($sformatf("rst_flags%0d", i), int'({opened[i], failed[i], lerr[i]}), 0);
        end

        // Verdict while idle is ignored.
        lock_open = 1'b1;
        tick();
        lock_open = 1'b0;
        for (int i = 0; i < 2; i++) chk($sformatf("idle_verdict%0d", i), int'(opened[i]), 0);

        // Directed load sequence with rejections and a premature start.
        do_load(4'd3, 1'b0); do_load(4'd2, 1'b0); do_load(4'd0, 1'b0); do_load(4'd4, 1'b0);
        do_load(4'd12, 1'b0);
        do_load(4'd7, 1'b0);
        do_start(1'b0);
        do_load(4'd4, 1'b0);
        do_load(4'd5, 1'b0);

        // Straight send with ready held high, lock opens.
        digit_ready = 1'b1;
        do_start(1'b1);
        wait_sent(1'b0);
        for (int i = 0; i < 2; i++) chk($sformatf("wait_busy%0d", i), int'(busy[i]), 1);
        verdict(1'b1, 1'b0);

        // Commands and verdicts during a send are ignored; random stalls.
        do_start(1'b1);
        load_en = 1'b1; clear = 1'b1; load_digit = 4'd1; lock_open = 1'b1;
        tick();
        load_en = 1'b0; clear = 1'b0; lock_open = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("busy_load_count%0d", i), int'(lcnt[i]), ND);
            chk($sformatf("busy_load_err%0d", i), int'(lerr[i]), 0);
            chk($sformatf("busy_verdict%0d", i), int'(opened[i]), 0);
        end
        wait_sent(1'b1);
`ifdef COMBO_DIALER_TIMEOUT_EN
        begin
            int seen [2];
            int n = 0;
            seen[0] = -1; seen[1] = -1;
            while ((seen[0] < 0 || seen[1] < 0) && n < 300) begin
                tick();
                n++;
                for (int i = 0; i < 2; i++)
                    if (seen[i] < 0 && failed[i]) seen[i] = cyc;
            end
            for (int i = 0; i < 2; i++)
                chk($sformatf("timeout_cycles%0d", i), seen[i] - entry_cyc[i], TMO);
            failed_m = 1'b1;
            tick(); tick();
            for (int i = 0; i < 2; i++) chk($sformatf("timeout_idle%0d", i), int'(busy[i]), 0);
        end
`else
        repeat (80) tick();
        for (int i = 0; i < 2; i++) chk($sformatf("no_timeout_busy%0d", i), int'(busy[i]), 1);
        verdict(1'b0, 1'b1);
`endif

        // Simultaneous verdicts: fail dominates; then resend the retained code.
        do_start(1'b1);
        wait_sent(1'b1);
        verdict(1'b1, 1'b1);
        do_start(1'b1);
        wait_sent(1'b1);
        verdict(1'b1, 1'b0);

        // Reset during the fourth digit.
        do_start(1'b1);
        begin
            int n = 0;
            digit_ready = 1'b1;
            while (hs_cnt[0] < 3 && n < 200) begin
                tick();
                n++;
            end
            chk("reach_digit4", hs_cnt[0], 3);
        end
        rst = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("midrst_busy%0d", i), int'(busy[i]), 0);
            chk($sformatf("midrst_count%0d", i), int'(lcnt[i]), 0);
            chk($sformatf("midrst_valid%0d", i), int'(d_valid[i]), 0);
        end
        rst = 1'b0;
        digit_ready = 1'b0;
        cnt_m = 0;
        code_m.delete();
        opened_m = 1'b0;
        failed_m = 1'b0;

        // Clear beats a simultaneous load.
        do_load(4'd8, 1'b0);
        do_load(4'd1, 1'b0);
        do_load(4'd6, 1'b1);

        // Random codes with occasional invalid digits and random verdicts.
        for (int r = 0; r < 4; r++) begin
            int n = 0;
            do_load(4'd0, 1'b1);
            while (cnt_m < ND && n < 40) begin
                do_load(4'($urandom_range(0, 11)), 1'b0);
                n++;
            end
            do_start(1'(cnt_m == ND));
            if (cnt_m == ND) begin
                wait_sent(1'b1);
                random_verdict();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/combo_dialer.md
Name: combo_dialer

Overview:
- Transmitter counterpart to the combination-lock digit receiver.
- Holds a programmed code of NDIGITS decimal digits.
- On command, it sends the code one digit per valid/ready handshake, with an optional inter-digit gap, then waits for the lock's open/closed verdict and reports it.
- Sits between the board switch/key logic and a lock block, or between a test harness and a lock block.

Parameters:
- NDIGITS, 6, number of digits in the code (2..8).
- GAP_CYCLES, 0, idle cycles with digit_valid low between consecutive digit handshakes.
- TIMEOUT_CYCLES, 64, cycles allowed in WAIT_RESULT; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- load_en  in  1  append load_digit to the code (IDLE only)
- load_digit  in  4  digit to append
- clear  in  1  empty the code store (IDLE only)
- start  in  1  begin transmission (IDLE and code_full only)
- digit_out  out  4  current digit to the lock
- digit_valid  out  1  digit_out is valid
- digit_ready  in  1  lock accepts the digit
- lock_open  in  1  lock verdict: opened
- lock_closed  in  1  lock verdict: stayed closed
- busy  out  1  high in any state other than IDLE
- code_full  out  1  NDIGITS digits loaded
- load_count  out  4  number of digits loaded
- load_err  out  1  one-cycle pulse when a load is rejected
- opened  out  1  sticky pass flag; cleared on start
- failed  out  1  sticky fail flag; cleared on start

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, code store zero, load_count 0, all 1-bit outputs 0, digit_out 0.
- States: IDLE, SEND, GAP, WAIT_RESULT, DONE.
- IDLE, load:
  - load_en with load_digit <= 9 and load_count < NDIGITS: store the digit at index load_count; load_count increments next cycle.
  - load_en with load_digit > 9: rejected, load_err pulses for one cycle, nothing stored.
  - load_en when code_full: rejected, load_err pulses, nothing stored.
  - load_en together with clear: clear wins; load_count goes to 0 and load_err stays low.
- IDLE, start:
  - start with code_full: go to SEND, index = 0, opened = failed = 0.
  - start without code_full: ignored, no other effect.
- SEND:
  - digit_valid = 1; digit_out = code[index].
  - On digit_valid & digit_ready:
    - If index == NDIGITS-1: go to WAIT_RESULT.
    - Else if GAP_CYCLES == 0: stay in SEND with index+1; the next digit is valid the following cycle.
    - Else: go to GAP with counter = GAP_CYCLES.
  - digit_out and digit_valid hold stable until the handshake.
- GAP: digit_valid = 0; the counter decrements; at 1, go to SEND with index+1.
- WAIT_RESULT:
  - digit_valid = 0.
  - lock_open alone: opened = 1.
  - lock_closed, or both verdicts high together: failed = 1 (fail dominates).
  - Either verdict moves the FSM to DONE.
- DONE: one cycle, then IDLE. The code store is retained, so start can resend.
- Verdicts arriving in IDLE, SEND or GAP are ignored.
- load_en, clear and start outside IDLE are ignored. load_err is not pulsed for these.
- rst mid-transmission: immediate return to reset values, code store included.
- Latency: start to first digit_valid is 1 cycle. Minimum send time is NDIGITS + (NDIGITS-1)*GAP_CYCLES cycles with digit_ready held high.

Optional Feature:
- Macro: COMBO_DIALER_TIMEOUT_EN.
- Defined: a counter is loaded with TIMEOUT_CYCLES on entry to WAIT_RESULT. If it reaches 0 with no verdict, failed = 1 and the FSM goes to DONE.
- Not defined: WAIT_RESULT waits indefinitely, and no timeout counter is synthesised.

Decomposition:
- Package combo_pkg:
  - dialer_state_t enum (IDLE, SEND, GAP, WAIT_RESULT, DONE).
  - DIGIT_W = 4 and DIGIT_MAX = 9.
  - Shared with the lock receiver.
- Sub-module combo_code_store:
  - NDIGITS x 4-bit register file with append/clear/read-by-index.
  - Exports load_count, code_full and load_err.
- The FSM, gap counter and timeout counter stay in combo_dialer.

Test Plan:
- Load 3,2,0,4,7,4 (NDIGITS=6), start, digit_ready held 1, GAP_CYCLES=0 -> digit_out 3,2,0,4,7,4 on six consecutive cycles with digit_valid=1, then WAIT_RESULT; lock_open -> opened=1, busy=0 two cycles later.
- Load digit 12 -> load_err pulses, load_count unchanged. Load a 7th digit when full -> load_err pulses. start with load_count=5 -> busy stays 0.
- GAP_CYCLES=2, digit_ready stalled 3 cycles on digit 2 -> digit_out holds, then exactly 2 invalid cycles between every accepted digit.
- lock_open and lock_closed high in the same cycle -> failed=1, opened=0. A second start -> both flags clear, same code resent.
- rst asserted during digit 4 -> next cycle busy=0, load_count=0, digit_valid=0.
- With COMBO_DIALER_TIMEOUT_EN, TIMEOUT_CYCLES=64, no verdict -> failed=1 exactly 64 cycles after WAIT_RESULT entry. Without the macro -> busy stays 1.
